// File: rtl/mxv_protocol_pkg.sv
// Shared MxV UART protocol constants: frame delimiters, command codes and the
// result-transmitter state encoding.
package mxv_protocol_pkg;

  localparam logic [7:0] FRAME_SOF  = 8'hFE;
  localparam logic [7:0] FRAME_EOF  = 8'hEF;

  localparam logic [7:0] CMD_SIZE   = 8'h01;
  localparam logic [7:0] CMD_INIT   = 8'h03;
  localparam logic [7:0] CMD_MATRIX = 8'h04;
  localparam logic [7:0] CMD_RESULT = 8'h05;

  typedef enum logic [2:0] {
    IDLE,
    SEND_SOF,
    SEND_LEN,
    SEND_CMD,
    SEND_DATA,
    SEND_EOF,
    WAIT_TX,
    DONE
  } tx_state_t;

endpackage

// File: rtl/result_byte_selector.sv
// Holds the result vector captured at frame start and picks the payload byte
// for a byte index: element idx>>1, high byte on even idx, low byte on odd idx.
module result_byte_selector #(
  parameter int WORD_LENGTH  = 8,
  parameter int RESULT_WIDTH = 16,
  parameter int MAX_N        = 8,
  parameter int IDX_W        = $clog2(2 * MAX_N)
) (
  input  logic                            clk,
  input  logic                            load_i,
  input  logic [MAX_N*RESULT_WIDTH-1:0]   vector_i,
  input  logic [IDX_W-1:0]                byte_idx_i,
  output logic [WORD_LENGTH-1:0]          byte_o
);

  logic [MAX_N*RESULT_WIDTH-1:0] vector_q;
  logic [RESULT_WIDTH-1:0]       elem;

  always_ff @(posedge clk) begin
    if (load_i) vector_q <= vector_i;
  end

  always_comb begin
    elem = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (byte_idx_i[IDX_W-1:1] == (IDX_W-1)'(i)) elem = vector_q[i*RESULT_WIDTH +: RESULT_WIDTH];
    end
    byte_o = byte_idx_i[0] ? elem[WORD_LENGTH-1:0] : elem[RESULT_WIDTH-1 -: WORD_LENGTH];
  end

endmodule

// File: rtl/result_frame_transmitter.sv
// Serialises the MxV result vector into one UART frame: FE, LEN, CMD, payload, EF,
// one byte per TX handshake with a guard cycle after every send strobe.
module result_frame_transmitter
  import mxv_protocol_pkg::*;
#(
  parameter int         WORD_LENGTH  = 8,
  parameter int         RESULT_WIDTH = 16,
  parameter int         MAX_N        = 8,
  parameter logic [7:0] CMD_RESULT   = mxv_protocol_pkg::CMD_RESULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [3:0]                    size,
  input  logic [MAX_N*RESULT_WIDTH-1:0] result_vector,
  input  logic                          tx_ready,
  output logic [WORD_LENGTH-1:0]        tx_data,
  output logic                          tx_send,
  output logic                          busy,
  output logic                          done,
  output logic                          size_error
);

  localparam int         CNT_W   = $clog2(2 * MAX_N);
  localparam logic [3:0] MAX_N_L = 4'(MAX_N);

  tx_state_t               state_q, state_d;
  tx_state_t               ret_q, ret_d;
  tx_state_t               after_send;
  logic                    guard_q, guard_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    size_err_q, size_err_d;
  logic [WORD_LENGTH-1:0]  tx_data_q;
  logic [3:0]              n_q;
  logic                    load;
  logic                    in_send;
  logic                    last_data;
  logic [WORD_LENGTH-1:0]  send_byte;
  logic [WORD_LENGTH-1:0]  payload_byte;
  logic [WORD_LENGTH-1:0]  len_byte;

  result_byte_selector #(
    .WORD_LENGTH  (WORD_LENGTH),
    .RESULT_WIDTH (RESULT_WIDTH),
    .MAX_N        (MAX_N),
    .IDX_W        (CNT_W)
  ) u_sel (
    .clk        (clk),
    .load_i     (load),
    .vector_i   (result_vector),
    .byte_idx_i (cnt_q),
    .byte_o     (payload_byte)
  );

  // LEN covers CMD + 2N payload bytes + EF
  assign len_byte  = WORD_LENGTH'({n_q, 1'b0}) + WORD_LENGTH'(2);
  assign last_data = (cnt_q == CNT_W'({n_q, 1'b0} - 5'd1));

  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    guard_d    = guard_q;
    cnt_d      = cnt_q;
    size_err_d = 1'b0;
    load       = 1'b0;
    in_send    = 1'b0;
    send_byte  = FRAME_SOF;
    after_send = IDLE;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (size != 4'd0 && size <= MAX_N_L) begin
            load    = 1'b1;
            cnt_d   = '0;
            state_d = SEND_SOF;
          end else begin
            size_err_d = 1'b1;
          end
        end
      end
      SEND_SOF: begin
        in_send    = 1'b1;
        send_byte  = FRAME_SOF;
        after_send = SEND_LEN;
      end
      SEND_LEN: begin
        in_send    = 1'b1;
        send_byte  = len_byte;
        after_send = SEND_CMD;
      end
      SEND_CMD: begin
        in_send    = 1'b1;
        send_byte  = CMD_RESULT;
        after_send = SEND_DATA;
      end
      SEND_DATA: begin
        in_send    = 1'b1;
        send_byte  = payload_byte;
        after_send = last_data ? SEND_EOF : SEND_DATA;
        if (tx_ready) cnt_d = cnt_q + CNT_W'(1);
      end
      SEND_EOF: begin
        in_send    = 1'b1;
        send_byte  = FRAME_EOF;
        after_send = DONE;
      end
      WAIT_TX: begin
        // first cycle here is the guard; tx_ready is only honoured afterwards
        if (guard_q)       guard_d = 1'b0;
        else if (tx_ready) state_d = ret_q;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (in_send && tx_ready) begin
      state_d = WAIT_TX;
      ret_d   = after_send;
      guard_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ret_q      <= IDLE;
      guard_q    <= 1'b0;
      cnt_q      <= '0;
      size_err_q <= 1'b0;
      tx_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      guard_q    <= guard_d;
      cnt_q      <= cnt_d;
      size_err_q <= size_err_d;
      if (tx_send) tx_data_q <= send_byte;
    end
  end

  always_ff @(posedge clk) begin
    if (load) n_q <= size;
  end

  assign tx_send    = in_send & tx_ready;
  assign tx_data    = tx_send ? send_byte : tx_data_q;
  assign busy       = (state_q != IDLE) && (state_q != DONE);
  assign done       = (state_q == DONE);
  assign size_error = size_err_q;

endmodule
